multicycle_control_unit: RTL and testbench

Multi-cycle control FSM for the KGP-RISC datapath. It takes the opcode and function fields produced by the instruction decoder. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select, and handshakes with the single shared instruction/data memory port.

---
 rtl/multicycle_control_unit.sv | 164 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle control FSM for the KGP-RISC datapath
module multicycle_control_unit #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             opcode,
  input  logic [4:0]             func,
  input  logic                   rs_zero,
  input  logic                   mem_ack,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   addr_sel,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic [1:0]             pc_src,
  output logic                   alu_src_imm,
  output logic [4:0]             alu_op,
  output logic                   reg_write,
  output logic                   wb_sel,
  output logic                   halted,
  output logic                   illegal_op,
  output logic [2:0]             state,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_ADDI = 6'd1;
  localparam logic [5:0] OP_LW   = 6'd2;
  localparam logic [5:0] OP_SW   = 6'd3;
  localparam logic [5:0] OP_BZ   = 6'd4;
  localparam logic [5:0] OP_J    = 6'd5;
  localparam logic [5:0] OP_HALT = 6'd6;

  state_t                 state_q, state_d;
  logic [5:0]             opc_q, opc_d;
  logic [4:0]             func_q, func_d;
  logic                   illegal_q, illegal_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    func_d      = func_q;
    illegal_d   = illegal_q;
    count_d     = count_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    alu_src_imm = 1'b0;
    alu_op      = 5'd0;
    reg_write   = 1'b0;
    wb_sel      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Later states only see the latched fields; the decoder may move on.
        opc_d  = opcode;
        func_d = func;
        if (opcode <= OP_J) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          if (opcode != OP_HALT) illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        case (opc_q)
          OP_R: begin
            alu_op  = func_q;
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_src_imm = 1'b1;
            state_d     = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_imm = 1'b1;
            state_d     = S_MEM;
          end
          OP_BZ: begin
            pc_write = rs_zero;
            pc_src   = 2'd1;
            state_d  = S_FETCH;
          end
          default: begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
            state_d  = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opc_q == OP_SW);
        if (mem_ack) state_d = (opc_q == OP_SW) ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (opc_q == OP_LW);
        state_d   = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    if (state_d == S_FETCH && (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
      count_d = count_q + COUNT_WIDTH'(1);
    // Reset wins over any ack seen in the same cycle, so nothing commits.
    if (rst) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      addr_sel    = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'd0;
      alu_src_imm = 1'b0;
      alu_op      = 5'd0;
      reg_write   = 1'b0;
      wb_sel      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      opc_q     <= 6'd0;
      func_q    <= 5'd0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      func_q    <= func_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign halted      = (state_q == S_HALT);
  assign illegal_op  = illegal_q;
  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    opcode = 6'd0;
  logic [4:0]    func = 5'd0;
  logic          rs_zero = 1'b0;
  logic          mem_ack = 1'b0;
  logic          mem_req, mem_we, addr_sel, ir_write, pc_write;
  logic [1:0]    pc_src;
  logic          alu_src_imm;
  logic [4:0]    alu_op;
  logic          reg_write, wb_sel, halted, illegal_op;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  multicycle_control_unit #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .rs_zero(rs_zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_imm(alu_src_imm), .alu_op(alu_op), .reg_write(reg_write),
    .wb_sel(wb_sel), .halted(halted), .illegal_op(illegal_op), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] JUNK_OP = 6'h2a;
  localparam logic [4:0] JUNK_FN = 5'h15;

  typedef struct {
    logic          ack;
    logic [5:0]    opc;
    logic [4:0]    fn;
    logic          rz;
    logic [2:0]    st;
    logic [20:0]   exp;
  } rec_t;

  typedef struct {
    int op; int fn; int rz; int fw; int mw; int lat;
  } vec_t;

  rec_t  exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    exp_cnt = 0;
  logic  exp_ill = 1'b0;
  string cur_test = "";

  function automatic logic [16:0] ov(input logic req, we, asel, irw, pcw,
                                     input logic [1:0] pcs, input logic imm,
                                     input logic [4:0] aop, input logic rw, wbs, hlt);
    return {req, we, asel, irw, pcw, pcs, imm, aop, rw, wbs, hlt, 1'b0};
  endfunction

  function automatic logic [20:0] actual_outs();
    return {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src_imm,
            alu_op, reg_write, wb_sel, halted, illegal_op, instr_count};
  endfunction

  task automatic add(input logic ack, input logic [5:0] opc, input logic [4:0] fn,
                     input logic rz, input logic [2:0] st, input logic [16:0] o);
    rec_t r;
    logic [CW-1:0] c;
    c = exp_cnt[CW-1:0];
    r.ack = ack; r.opc = opc; r.fn = fn; r.rz = rz; r.st = st;
    r.exp = {o | {16'b0, exp_ill}, c};
    exp_q.push_back(r);
  endtask

  task automatic push_instr(input int op, input int fn, input int rz,
                            input int fw, input int mw, input int nh);
    logic [5:0] o6;
    logic [4:0] f5;
    o6 = op[5:0];
    f5 = fn[4:0];
    for (int i = 0; i < fw; i++)
      add(1'b0, JUNK_OP, JUNK_FN, 1'b1, 3'd0, ov(1,0,0,0,0,2'd0,0,5'd0,0,0,0));
    add(1'b1, JUNK_OP, JUNK_FN, 1'b1, 3'd0, ov(1,0,0,1,1,2'd0,0,5'd0,0,0,0));
    add(1'b1, o6, f5, 1'b1, 3'd1, ov(0,0,0,0,0,2'd0,0,5'd0,0,0,0));
    if (op >= 6) begin
      if (op != 6) exp_ill = 1'b1;
      for (int i = 0; i < nh; i++)
        add(1'b1, JUNK_OP, JUNK_FN, 1'b1, 3'd5, ov(0,0,0,0,0,2'd0,0,5'd0,0,0,1));
      return;
    end
    case (op)
      0: begin
        add(1'b1, JUNK_OP, JUNK_FN, 1'b1, 3'd2, ov(0,0,0,0,0,2'd0,0,f5,0,0,0));
        add(1'b1, JUNK_OP, JUNK_FN, 1'b1, 3'd4, ov(0,0,0,0,0,2'd0,0,5'd0,1,0,0));
      end
      1: begin
        add(1'b1, JUNK_OP, JUNK_FN, 1'b1, 3'd2, ov(0,0,0,0,0,2'd0,1,5'd0,0,0,0));
        add(1'b1, JUNK_OP, JUNK_FN, 1'b1, 3'd4, ov(0,0,0,0,0,2'd0,0,5'd0,1,0,0));
      end
      2, 3: begin
        add(1'b1, JUNK_OP, JUNK_FN, 1'b1, 3'd2, ov(0,0,0,0,0,2'd0,1,5'd0,0,0,0));
        for (int i = 0; i < mw; i++)
          add(1'b0, JUNK_OP, JUNK_FN, 1'b1, 3'd3, ov(1,op==3,1,0,0,2'd0,0,5'd0,0,0,0));
        add(1'b1, JUNK_OP, JUNK_FN, 1'b1, 3'd3, ov(1,op==3,1,0,0,2'd0,0,5'd0,0,0,0));
        if (op == 2)
          add(1'b1, JUNK_OP, JUNK_FN, 1'b1, 3'd4, ov(0,0,0,0,0,2'd0,0,5'd0,1,1,0));
      end
      4: add(1'b1, JUNK_OP, JUNK_FN, rz[0], 3'd2, ov(0,0,0,0,rz[0],2'd1,0,5'd0,0,0,0));
      default: add(1'b1, JUNK_OP, JUNK_FN, 1'b1, 3'd2, ov(0,0,0,0,1,2'd2,0,5'd0,0,0,0));
    endcase
    exp_cnt = (exp_cnt + 1) % (1 << CW);
  endtask

  task automatic run_queue(input int n, output int nonfetch);
    rec_t r;
    int   k;
    logic [20:0] got;
    nonfetch = 0;
    k = 0;
    while (exp_q.size() > 0 && (n < 0 || k < n)) begin
      r = exp_q.pop_front();
      @(negedge clk);
      rst = 1'b0; mem_ack = r.ack; opcode = r.opc; func = r.fn; rs_zero = r.rz;
      #1;
      checks++;
      if (state !== r.st) begin
        failures++;
        $display("FAIL %s cyc%0d state got=%0d exp=%0d", cur_test, k, state, r.st);
      end
      got = actual_outs();
      checks++;
      if (got !== r.exp) begin
        failures++;
        $display("FAIL %s cyc%0d outputs got=%h exp=%h", cur_test, k, got, r.exp);
      end
      if (state != 3'd0) nonfetch++;
      k++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b1; opcode = JUNK_OP;
    #1;
    checks++;
    if ({mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write} !== 6'b0) begin
      failures++;
      $display("FAIL %s rst_gating got=%b exp=000000", cur_test,
               {mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({state, halted, illegal_op, instr_count, mem_req} !== {3'd0, 1'b0, 1'b0, {CW{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL %s rst_state got st=%0d h=%b ill=%b cnt=%0d req=%b exp 0", cur_test,
               state, halted, illegal_op, instr_count, mem_req);
    end
    exp_cnt = 0;
    exp_ill = 1'b0;
  endtask

  vec_t vecs[10];
  int   nf;

  initial begin
    vecs[0] = '{0, 0,     0, 0, 0, 4};
    vecs[1] = '{0, 'h13,  0, 2, 0, 6};
    vecs[2] = '{1, 0,     0, 0, 0, 4};
    vecs[3] = '{2, 0,     0, 0, 3, 8};
    vecs[4] = '{2, 0,     0, 0, 0, 5};
    vecs[5] = '{3, 0,     0, 0, 0, 4};
    vecs[6] = '{3, 0,     0, 1, 2, 7};
    vecs[7] = '{4, 0,     1, 0, 0, 3};
    vecs[8] = '{4, 0,     0, 0, 0, 3};
    vecs[9] = '{5, 0,     0, 0, 0, 3};

    cur_test = "reset";
    do_reset();

    for (int i = 0; i < 10; i++) begin
      $sformat(cur_test, "vec%0d_op%0d", i, vecs[i].op);
      push_instr(vecs[i].op, vecs[i].fn, vecs[i].rz, vecs[i].fw, vecs[i].mw, 0);
      run_queue(-1, nf);
      checks++;
      if (nf != vecs[i].lat - 1 - vecs[i].fw) begin
        failures++;
        $display("FAIL %s latency got=%0d exp=%0d", cur_test, nf + 1 + vecs[i].fw, vecs[i].lat);
      end
    end

    cur_test = "sw_rst_in_mem";
    push_instr(3, 0, 1, 0, 0, 0);
    run_queue(3, nf);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b1; opcode = JUNK_OP;
    #1;
    checks++;
    if ({state, mem_req, pc_write, reg_write, mem_we} !== {3'd3, 4'b0000}) begin
      failures++;
      $display("FAIL %s mem_cycle got st=%0d req=%b pcw=%b rw=%b we=%b exp st=3 rest 0",
               cur_test, state, mem_req, pc_write, reg_write, mem_we);
    end
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b0;
    #1;
    checks++;
    if ({state, mem_we, mem_req, addr_sel, instr_count} !== {3'd0, 1'b0, 1'b1, 1'b0, {CW{1'b0}}}) begin
      failures++;
      $display("FAIL %s after got st=%0d we=%b req=%b asel=%b cnt=%0d exp st=0 we=0 req=1 asel=0 cnt=0",
               cur_test, state, mem_we, mem_req, addr_sel, instr_count);
    end
    exp_cnt = 0;
    exp_ill = 1'b0;

    cur_test = "halt_op6";
    push_instr(6, 0, 0, 0, 0, 5);
    run_queue(-1, nf);
    do_reset();

    cur_test = "illegal_op9";
    push_instr(1, 0, 0, 0, 0, 0);
    push_instr(9, 0, 0, 0, 0, 20);
    run_queue(-1, nf);
    cur_test = "illegal_clear";
    do_reset();

    cur_test = "j_wrap";
    for (int i = 0; i < 16; i++) push_instr(5, 0, 0, 0, 0, 0);
    run_queue(-1, nf);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({state, instr_count} !== {3'd0, {CW{1'b0}}}) begin
      failures++;
      $display("FAIL %s count got st=%0d cnt=%0d exp st=0 cnt=0", cur_test, state, instr_count);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
